// File: rtl/keypad_pkg.sv
// Shared types, keymap and small helpers for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic {SCAN, HOLD} scan_state_t;

  localparam logic [3:0] COL_INIT = 4'b1110;

  // Indexed [row][col]; '*' encodes as E and '#' as F.
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] rotate_cols(input logic [3:0] cols);
    return {cols[2:0], cols[3]};
  endfunction

  function automatic logic cols_legal(input logic [3:0] cols);
    return (cols == 4'b1110) || (cols == 4'b1101) ||
           (cols == 4'b1011) || (cols == 4'b0111);
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port connection.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_pressed;
  logic       new_key;

  modport master (
    input  rows,
    output cols,
    output key_code,
    output key_pressed,
    output new_key
  );

  modport slave (
    output rows,
    input  cols,
    input  key_code,
    input  key_pressed,
    input  new_key
  );
endinterface

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle
// level of pulled-up, active-low lines).
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a one-cold column drive, captures the first
// pressed key, and holds its code until that key is released.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 48000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  scan_state_t      state_q, state_d;
  logic [3:0]       cols_q, cols_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_pressed_q, key_pressed_d;
  logic             new_key_q, new_key_d;
  logic [1:0]       row_q, row_d;

  logic [3:0]       rows_s;
  logic             dwell_end;
  logic [1:0]       hit_row;
  logic [1:0]       hit_col;

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rows),
    .q     (rows_s)
  );

  always_comb begin
    dwell_end = (cnt_q == CNT_LAST);
    hit_row   = lowest_low_row(rows_s);
    hit_col   = col_index(cols_q);
  end

  always_comb begin
    state_d       = state_q;
    cols_d        = cols_q;
    cnt_d         = dwell_end ? '0 : cnt_q + CNT_W'(1);
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    new_key_d     = 1'b0;
    row_d         = row_q;

    case (state_q)
      SCAN: begin
        if (!cols_legal(cols_q)) begin
          cols_d = COL_INIT;
        end else if (dwell_end) begin
          if (rows_s == 4'b1111) begin
            cols_d = rotate_cols(cols_q);
          end else begin
            // Column stays put so the held row can be watched for release.
            row_d         = hit_row;
            key_code_d    = KEYMAP[hit_row][hit_col];
            key_pressed_d = 1'b1;
            new_key_d     = 1'b1;
            state_d       = HOLD;
          end
        end
      end
      HOLD: begin
        if (!cols_legal(cols_q)) begin
          cols_d        = COL_INIT;
          key_pressed_d = 1'b0;
          state_d       = SCAN;
        end else if (dwell_end && rows_s[row_q]) begin
          cols_d        = rotate_cols(cols_q);
          key_pressed_d = 1'b0;
          state_d       = SCAN;
        end
      end
      default: begin
        cols_d        = COL_INIT;
        key_pressed_d = 1'b0;
        state_d       = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SCAN;
      cols_q        <= COL_INIT;
      cnt_q         <= '0;
      key_code_q    <= 4'h0;
      key_pressed_q <= 1'b0;
      new_key_q     <= 1'b0;
      row_q         <= 2'd0;
    end else begin
      state_q       <= state_d;
      cols_q        <= cols_d;
      cnt_q         <= cnt_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      new_key_q     <= new_key_d;
      row_q         <= row_d;
    end
  end

  assign bus.cols        = cols_q;
  assign bus.key_code    = key_code_q;
  assign bus.key_pressed = key_pressed_q;
  assign bus.new_key     = new_key_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the columns of a 4x4 matrix keypad and samples its rows.
- Encodes the first pressed key into a 4-bit hex code and holds it while the key stays down.
- Sits upstream of the keypad debouncer and produces its sig_in/key_pressed inputs.
- Performs no debouncing; bounce filtering is the debouncer's job.

Parameters:
- SCAN_DIV, 48000, clk cycles each column is driven before rows are sampled (1 ms at the 48 MHz HSOSC).

Ports:
- clk  input  1  system clock (48 MHz HSOSC).
- reset  input  1  asynchronous, active-low reset.
- rows  input  4  raw keypad rows, active-low (FPGA pull-ups); asynchronous to clk.
- cols  output  4  column drive, one-cold; the active column is 0, all others 1.
- key_code  output  4  hex code of the held key; valid while key_pressed=1.
- key_pressed  output  1  high while a captured key remains down.
- new_key  output  1  one-cycle pulse on the clk after a key is captured.

Behaviour:
- Reset is asynchronous, active-low:
  - state=SCAN, cols=4'b1110 (col0 active), counter=0.
  - key_code=0, key_pressed=0, new_key=0.
  - Both row synchronizer stages reset to 4'b1111.
- Row input: two-flop synchronizer; logic uses only rows_s.
- Dwell counter:
  - Width $clog2(SCAN_DIV); counts 0..SCAN_DIV-1, then wraps to 0.
  - "Dwell end" means counter==SCAN_DIV-1. Decisions are made only at dwell end.
- SCAN state, at dwell end:
  - If rows_s==4'b1111: rotate cols 1110->1101->1011->0111->1110 and stay in SCAN.
  - Otherwise: capture the lowest-index low row r and the current column c. Register key_code=KEYMAP[r][c], key_pressed=1, new_key=1. Go to HOLD. cols are not rotated.
- HOLD state:
  - cols frozen; new_key=0 from the second HOLD cycle onward.
  - At each dwell end, if rows_s[r]==0, stay in HOLD.
  - If rows_s[r]==1: clear key_pressed, rotate cols to the next column, go to SCAN. key_code keeps its last value.
- Other rows going low in HOLD (same column) are ignored.
- A second key held on release of the first is found on a later scan visit and raises new_key again.
- Keymap (row, col0..col3):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Latency:
  - The rows change becomes visible in rows_s after 2 clk.
  - key_pressed/new_key rise 1 clk after the dwell end that sees the press.
  - Worst-case press-to-detect is 4*SCAN_DIV+3 clk.
- Illegal state encoding: recover to SCAN with cols=4'b1110.
- Reset asserted mid-HOLD: all outputs clear immediately, without waiting for clk.

Decomposition:
- keypad_pkg holds:
  - typedef enum logic {SCAN, HOLD} scan_state_t.
  - localparam logic [3:0] KEYMAP[4][4].
  - localparam COL_INIT=4'b1110.
- Sub-module sync2 (parameterised width, asynchronous active-low reset to all-ones) holds the row synchronizer. It is reusable by the debouncer.

Test Plan:
- Rotation: SCAN_DIV=4, rows=4'hF, release reset -> cols 1110,1101,1011,0111,1110 every 4 clk; key_pressed=0, new_key=0 throughout.
- Single press '5': bench pulls rows[1] low whenever cols[1]==0 -> key_code=4'h5, key_pressed=1, exactly one new_key pulse, cols held at 1101.
- Release: drop the '5' press -> key_pressed=0 at the next dwell end +1 clk; cols advance to 1011; no new_key pulse.
- Two keys, one column: hold '2' (r0,c1) and '8' (r2,c1) -> code 4'h2. Release '2' only -> key_pressed falls, then '8' is detected on the next c1 visit -> code 4'h8, second new_key pulse.
- Corner codes: press '#' (r3,c2) -> 4'hF; press 'D' (r3,c3) -> 4'hD; press '*' (r3,c0) -> 4'hE.
- Reset mid-HOLD: assert reset between clk edges while '9' is held -> key_pressed=0, key_code=0, cols=1110 with no clk edge. After release, '9' is re-detected with code 4'h9.
